dwc_lpddr5xphy_pclk_rx_qual: RTL



---
 rtl/dwc_lpddr5xphy_pclk_rx_pkg.sv | 16 +
 rtl/dwc_lpddr5xphy_pclk_rx_sync.sv | 27 ++
 rtl/dwc_lpddr5xphy_pclk_rx_qual.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dwc_lpddr5xphy_pclk_rx_pkg.sv
// Shared types and constants for the PCLK receive-end qualifier.
`timescale 1ns/100ps
package dwc_lpddr5xphy_pclk_rx_pkg;

  localparam int                    EDGE_CNT_W   = 8;
  localparam logic [EDGE_CNT_W-1:0] EDGE_CNT_MAX = 8'd255;
  localparam int                    GOOD_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } pclk_rx_state_e;

endpackage

// File: rtl/dwc_lpddr5xphy_pclk_rx_sync.sv
// Multi-flop synchronizer for the asynchronous PclkRx plus rising-edge detect.
`timescale 1ns/100ps
module dwc_lpddr5xphy_pclk_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_ref_clk,
  input  logic i_ref_rst_n,
  input  logic i_pclk_rx,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_ref_clk or negedge i_ref_rst_n) begin
    if (!i_ref_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pclk_rx};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/dwc_lpddr5xphy_pclk_rx_qual.sv
// Receive-end PCLK qualifier: counts PclkRx edges per RefClk window and tracks lock.
// Optional: define DWC_LPDDR5XPHY_PCLK_RX_STICKY_LOSS_EN to make LOST sticky until Enable=0/reset.
//
// state   | meaning
// IDLE    | disabled, counters held at 0
// ACQUIRE | counting consecutive good windows toward lock
// LOCKED  | clock qualified, PclkGood=1
// LOST    | out-of-range window seen, PclkLost=1
`timescale 1ns/100ps
module dwc_lpddr5xphy_pclk_rx_qual
  import dwc_lpddr5xphy_pclk_rx_pkg::*;
#(
  parameter int WIN_LEN     = 64,
  parameter int MIN_EDGES   = 6,
  parameter int MAX_EDGES   = 10,
  parameter int LOCK_CNT    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  RefClk,
  input  logic                  RefRstN,
  input  logic                  Enable,
  input  logic                  PclkRx,
  output logic                  PclkGood,
  output logic                  PclkLost,
  output logic [EDGE_CNT_W-1:0] EdgeCount,
  output logic                  WinDone
);

  localparam int                    WIN_W     = $clog2(WIN_LEN);
  localparam logic [WIN_W-1:0]      WIN_LAST  = WIN_W'(WIN_LEN - 1);
  localparam logic [EDGE_CNT_W-1:0] EDGE_LO   = EDGE_CNT_W'(MIN_EDGES);
  localparam logic [EDGE_CNT_W-1:0] EDGE_HI   = EDGE_CNT_W'(MAX_EDGES);
  localparam logic [GOOD_CNT_W-1:0] LOCK_LAST = GOOD_CNT_W'(LOCK_CNT - 1);

  pclk_rx_state_e        r_state, w_state_nxt;
  logic [WIN_W-1:0]      r_win_cnt;
  logic [EDGE_CNT_W-1:0] r_edge_cnt;
  logic [EDGE_CNT_W-1:0] r_edge_count;
  logic [EDGE_CNT_W-1:0] w_edge_total;
  logic [GOOD_CNT_W-1:0] r_good_cnt, w_good_cnt_nxt;
  logic                  w_edge, w_run, w_term, w_win_good;

  dwc_lpddr5xphy_pclk_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_ref_clk   (RefClk),
    .i_ref_rst_n (RefRstN),
    .i_pclk_rx   (PclkRx),
    .o_edge      (w_edge)
  );

  assign w_run  = (r_state != ST_IDLE) && Enable;
  assign w_term = w_run && (r_win_cnt == WIN_LAST);

  // Terminal-cycle edge is folded in here so it lands in the closing window.
  assign w_edge_total = (w_edge && (r_edge_cnt != EDGE_CNT_MAX)) ?
                        r_edge_cnt + EDGE_CNT_W'(1) : r_edge_cnt;
  assign w_win_good   = (w_edge_total >= EDGE_LO) && (w_edge_total <= EDGE_HI);

  always_ff @(posedge RefClk or negedge RefRstN) begin
    if (!RefRstN) begin
      r_win_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_edge_count <= '0;
    end else if (!w_run) begin
      r_win_cnt    <= '0;
      r_edge_cnt   <= '0;
    end else if (w_term) begin
      r_win_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_edge_count <= w_edge_total;
    end else begin
      r_win_cnt    <= r_win_cnt + WIN_W'(1);
      r_edge_cnt   <= w_edge_total;
    end
  end

  always_ff @(posedge RefClk or negedge RefRstN) begin
    if (!RefRstN) begin
      r_state    <= ST_IDLE;
      r_good_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_good_cnt_nxt = r_good_cnt;
    PclkGood       = (r_state == ST_LOCKED);
    PclkLost       = (r_state == ST_LOST);
    WinDone        = w_term;
    if (!Enable) begin
      w_state_nxt    = ST_IDLE;
      w_good_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (w_term) begin
            if (!w_win_good) begin
              w_good_cnt_nxt = '0;
            end else begin
              w_good_cnt_nxt = r_good_cnt + GOOD_CNT_W'(1);
              if (r_good_cnt == LOCK_LAST) w_state_nxt = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (w_term && !w_win_good) begin
            w_state_nxt    = ST_LOST;
            w_good_cnt_nxt = '0;
          end
        end
        ST_LOST: begin
`ifdef DWC_LPDDR5XPHY_PCLK_RX_STICKY_LOSS_EN
          w_state_nxt = ST_LOST;
`else
          if (w_term) begin
            w_state_nxt    = ST_ACQUIRE;
            w_good_cnt_nxt = '0;
          end
`endif
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign EdgeCount = r_edge_count;

endmodule
